// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU sharing controller.
package alu_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD    = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB    = 5'b00001;
  localparam logic [OP_W-1:0] OP_MUL    = 5'b00010;
  localparam logic [OP_W-1:0] OP_MSW    = 5'b00011;
  localparam logic [OP_W-1:0] OP_DIV    = 5'b00100;
  localparam logic [OP_W-1:0] OP_REM    = 5'b00101;
  localparam logic [OP_W-1:0] OP_PASS_S = 5'b10010;

  // Flag vector bit order is {N,Z,C,V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;
  localparam logic [FLAG_W-1:0] FLAGS_ERR = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // MSW/REM read ALU-internal state left behind by the last MUL/DIV
  function automatic logic needs_owner(input logic [OP_W-1:0] op);
    return (op == OP_MSW) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the requester that did not win last time wins a tie.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant_c,
  output logic accept_c
);

  logic last_grant;

  always_comb begin
    grant_c  = (valid0 && valid1) ? ~last_grant : valid1;
    accept_c = en && (valid0 || valid1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept_c) begin
      last_grant <= grant_c;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one multi-cycle ALU between two requesters, holding operands for a
// latency window and tracking which requester owns the product/remainder state.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT    = 1,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req0_r,
  input  logic [DATA_W-1:0] req0_s,
  input  logic [DATA_W-1:0] req1_r,
  input  logic [DATA_W-1:0] req1_s,
  output logic [DATA_W-1:0] alu_r,
  output logic [DATA_W-1:0] alu_s,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_y,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_err,
  output logic              busy
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic               owner, owner_valid;
  logic               grant, accept, idle;
  logic [OP_W-1:0]    win_op;
  logic [DATA_W-1:0]  win_r, win_s;
  logic               win_err;
  logic [FLAG_W-1:0]  alu_flags;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .en       (idle),
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .grant_c  (grant),
    .accept_c (accept)
  );

  // Winner mux and reject decision
  always_comb begin
    win_op  = grant ? req1_op : req0_op;
    win_r   = grant ? req1_r  : req0_r;
    win_s   = grant ? req1_s  : req0_s;
    win_err = ((win_op == OP_DIV) && (win_s == '0)) ||
              (needs_owner(win_op) && !(owner_valid && (owner == grant)));
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    alu_flags = '0;
    alu_flags[FLAG_N] = alu_n;
    alu_flags[FLAG_Z] = alu_z;
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idle      = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        idle = 1'b1;
        busy = 1'b0;
        if (accept) state_nxt = win_err ? ST_RESP : ST_EXEC;
      end
      ST_EXEC: begin
        if (count == '0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand hold, latency counter, response capture and ownership
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_r       <= '0;
      alu_s       <= '0;
      alu_op      <= OP_PASS_S;
      count       <= '0;
      rsp_id      <= 1'b0;
      rsp_y       <= '0;
      rsp_flags   <= '0;
      rsp_err     <= 1'b0;
      owner       <= 1'b0;
      owner_valid <= 1'b0;
    end else if (accept) begin
      rsp_id <= grant;
      if (win_err) begin
        rsp_err   <= 1'b1;
        rsp_y     <= '0;
        rsp_flags <= FLAGS_ERR;
      end else begin
        alu_r  <= win_r;
        alu_s  <= win_s;
        alu_op <= win_op;
        count  <= is_muldiv(win_op) ? CNT_W'(MULDIV_LAT - 1) : CNT_W'(ALU_LAT - 1);
      end
    end else if (state == ST_EXEC) begin
      if (count != '0) begin
        count <= count - CNT_W'(1);
      end else begin
        rsp_y     <= alu_y;
        rsp_flags <= alu_flags;
        rsp_err   <= 1'b0;
        if (is_muldiv(alu_op)) begin
          owner_valid <= 1'b1;
          owner       <= rsp_id;
        end
      end
    end
  end

endmodule
